ccff_chain_loader: RTL and testbench

Configuration-chain loader that drives the serial `ccff_head` input of a tile's configuration flip-flop chain, such as the frac_lut6 DFFRX1 memory of 64 SRAM bits plus 1 mode bit. It accepts configuration words over a valid/ready port and serializes exactly `CHAIN_LEN` bits into the chain. It produces a gated shift enable for the fabric's programming clock and flags completion. An optional CRC readback pass recirculates the chain through `ccff_tail` to check integrity without destroying its contents.

---
 rtl/ccff_loader_pkg.sv | 9 +
 rtl/ccff_chain_loader_if.sv | 8 +
 rtl/ccff_crc16_serial.sv | 17 +
 rtl/ccff_chain_loader.sv | 112 +++++++++++
 tb/tb_ccff_chain_loader.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg: shared FSM state type and CRC-16-CCITT helpers for the chain loader
package ccff_loader_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, VERIFY, DONE} state_t;
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        return {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC_POLY : 16'h0000);
    endfunction
endpackage

// File: rtl/ccff_chain_loader_if.sv
// ccff_chain_loader_if: valid/ready configuration word port
interface ccff_chain_loader_if #(parameter int WORD_W = 32);
    logic              valid;
    logic              ready;
    logic [WORD_W-1:0] data;
    modport master (output valid, output data, input ready);
    modport slave (input valid, input data, output ready);
endinterface

// File: rtl/ccff_crc16_serial.sv
// ccff_crc16_serial: bit-serial CRC-16-CCITT, one data bit per enabled prog_clk edge
module ccff_crc16_serial
    import ccff_loader_pkg::*;
(
    input  logic        prog_clk,
    input  logic        pReset,
    input  logic        clear,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) crc <= CRC_INIT;
        else if (clear) crc <= CRC_INIT;
        else if (en) crc <= crc16_step(crc, din);
    end
endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serializes CHAIN_LEN config bits into a ccff chain, MSB first.
// Define CCFF_READBACK_EN to add a non-destructive CRC readback pass through ccff_tail.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 65
) (
    input  logic               prog_clk,
    input  logic               pReset,
    input  logic               start,
    ccff_chain_loader_if.slave cfg,
    output logic               ccff_head,
    input  logic               ccff_tail,
    output logic               chain_shift_en,
    output logic               busy,
    output logic               done,
    output logic               crc_err
);
    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int WW = $clog2(WORD_W + 1);

    state_t            state, nxt;
    logic [WORD_W-1:0] shreg;
    logic [CW-1:0]     bit_cnt;
    logic [WW-1:0]     word_cnt;
    logic              last_bit, last_word, idle_like;

    assign last_bit  = bit_cnt == CW'(CHAIN_LEN - 1);
    assign last_word = word_cnt == WW'(WORD_W - 1);
    assign idle_like = state == IDLE || state == DONE;

`ifdef CCFF_READBACK_EN
    localparam state_t END_SHIFT = VERIFY;
`else
    localparam state_t END_SHIFT = DONE;
`endif

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE, DONE: nxt = start ? LOAD : state;
            LOAD:       nxt = cfg.valid ? SHIFT : LOAD;
            SHIFT:      nxt = last_bit ? END_SHIFT : (last_word ? LOAD : SHIFT);
            VERIFY:     nxt = last_bit ? DONE : VERIFY;
            default:    nxt = IDLE;
        endcase
    end

    // bit_cnt restarts at the end of SHIFT so VERIFY can reuse it for its CHAIN_LEN rotations
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
        end else begin
            state <= nxt;
            if (state == LOAD && cfg.valid) begin
                shreg    <= cfg.data;
                word_cnt <= '0;
            end else if (state == SHIFT) begin
                shreg    <= shreg << 1;
                word_cnt <= word_cnt + 1'b1;
            end
            if (idle_like || (state == SHIFT && last_bit)) bit_cnt <= '0;
            else if (state == SHIFT || state == VERIFY) bit_cnt <= bit_cnt + 1'b1;
        end
    end

    assign cfg.ready      = state == LOAD;
    assign busy           = state == LOAD || state == SHIFT || state == VERIFY;
    assign done           = state == DONE;
    assign chain_shift_en = state == SHIFT || state == VERIFY;

`ifdef CCFF_READBACK_EN
    logic [15:0] load_crc, rb_crc;

    assign ccff_head = state == SHIFT ? shreg[WORD_W-1] : (state == VERIFY && ccff_tail);

    ccff_crc16_serial u_load_crc (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .clear    (idle_like),
        .en       (state == SHIFT),
        .din      (shreg[WORD_W-1]),
        .crc      (load_crc)
    );

    ccff_crc16_serial u_rb_crc (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .clear    (idle_like),
        .en       (state == VERIFY),
        .din      (ccff_tail),
        .crc      (rb_crc)
    );

    // the last tail bit is folded in combinationally so the verdict lands with done
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) crc_err <= 1'b0;
        else if (state == VERIFY && last_bit) crc_err <= load_crc != crc16_step(rb_crc, ccff_tail);
        else if (idle_like && start) crc_err <= 1'b0;
    end
`else
    logic unused_tail;

    assign unused_tail = ccff_tail;
    assign ccff_head   = state == SHIFT && shreg[WORD_W-1];
    assign crc_err     = 1'b0;
`endif
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: scoreboard bench with a 65-stage chain model on ccff_head/ccff_tail
module tb_ccff_chain_loader;
    localparam int WORD_W    = 32;
    localparam int CHAIN_LEN = 65;
`ifdef CCFF_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    logic prog_clk = 1'b0;
    logic pReset   = 1'b0;
    logic start    = 1'b0;
    logic ccff_head, ccff_tail, chain_shift_en, busy, done, crc_err;

    ccff_chain_loader_if #(.WORD_W(WORD_W)) cfg ();

    ccff_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN)) dut (
        .prog_clk       (prog_clk),
        .pReset         (pReset),
        .start          (start),
        .cfg            (cfg.slave),
        .ccff_head      (ccff_head),
        .ccff_tail      (ccff_tail),
        .chain_shift_en (chain_shift_en),
        .busy           (busy),
        .done           (done),
        .crc_err        (crc_err)
    );

    always #5 prog_clk = ~prog_clk;

    logic [CHAIN_LEN-1:0] chain = '0;
    logic                 q[$];
    int                   n_cmp = 0, n_bad = 0;
    int                   cyc = 0, hs = 0, shifts = 0, sh0 = 0;
    bit                   flip_en = 1'b0;

    assign ccff_tail = chain[CHAIN_LEN-1];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // chain model; optionally corrupts bit 40 together with the last load shift
    always @(posedge prog_clk) begin
        cyc <= cyc + 1;
        if (chain_shift_en)
            chain <= {chain[CHAIN_LEN-2:0], ccff_head} ^
                     ((flip_en && shifts - sh0 == CHAIN_LEN) ? (CHAIN_LEN'(1) << 40) : '0);
    end

    always @(negedge prog_clk) begin
        if (cfg.valid && cfg.ready) hs <= hs + 1;
        if (chain_shift_en) begin
            shifts <= shifts + 1;
            if (q.size() > 0) check("head", 128'(ccff_head), 128'(q.pop_front()));
        end
    end

    task automatic send_word(input logic [31:0] w, input int nb);
        int n = 0;
        cfg.valid = 1'b1;
        cfg.data  = w;
        for (int j = 0; j < nb; j++) q.push_back(w[31-j]);
        while (n < 500) begin
            @(negedge prog_clk);
            n++;
            if (cfg.ready) break;
        end
        check("word_accept", 128'(cfg.ready), 128'(1));
        if (cfg.ready) begin
            @(posedge prog_clk);
            #1;
        end
    endtask

    task automatic run_load(input logic [31:0] w0, w1, w2, input bit stall, poke, flip);
        int                   t0, h0, n;
        logic [31:0]          w[3];
        logic [CHAIN_LEN-1:0] exp_chain;
        w       = '{w0, w1, w2};
        flip_en = flip;
        h0      = hs;
        sh0     = shifts;
        @(posedge prog_clk);
        #1;
        start = 1'b1;
        t0    = cyc;
        @(posedge prog_clk);
        #1;
        start = 1'b0;
        check("ready_after_start", 128'(cfg.ready), 128'(1));
        for (int k = 0; k < 3; k++) begin
            if (k == 1 && stall) begin
                n = 0;
                while (!cfg.ready && n < 500) begin
                    @(negedge prog_clk);
                    n++;
                end
                for (int i = 0; i < 10; i++) begin
                    check("stall_ready", 128'(cfg.ready), 128'(1));
                    check("stall_shift_en", 128'(chain_shift_en), 128'(0));
                    @(posedge prog_clk);
                    #1;
                end
            end
            send_word(w[k], (CHAIN_LEN - 32 * k) < 32 ? CHAIN_LEN - 32 * k : 32);
            if (k == 0 && stall) cfg.valid = 1'b0;
            if (k == 1 && poke) begin
                start = 1'b1;
                @(posedge prog_clk);
                #1;
                start = 1'b0;
                check("busy_after_poke", 128'(busy), 128'(1));
            end
        end
        cfg.valid = 1'b0;
        n = 0;
        while (!done && n < 2000) begin
            @(negedge prog_clk);
            n++;
        end
        check("done", 128'(done), 128'(1));
        if (done) check("latency", 128'(cyc - t0), 128'(69 + (stall ? 10 : 0) + RB * CHAIN_LEN));
        check("handshakes", 128'(hs - h0), 128'(3));
        check("shift_cycles", 128'(shifts - sh0), 128'(CHAIN_LEN * (1 + RB)));
        check("busy_in_done", 128'(busy), 128'(0));
        exp_chain = {w0, w1, w2[31]} ^ ((flip && RB == 1) ? (CHAIN_LEN'(1) << 40) : '0);
        check("chain", 128'(chain), 128'(exp_chain));
        check("crc_err", 128'(crc_err), 128'(flip && RB == 1));
        flip_en = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"}, 128'(cfg.ready), 128'(0));
        check({tag, "_head"}, 128'(ccff_head), 128'(0));
        check({tag, "_shift_en"}, 128'(chain_shift_en), 128'(0));
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_done"}, 128'(done), 128'(0));
        check({tag, "_crc_err"}, 128'(crc_err), 128'(0));
    endtask

    initial begin
        cfg.valid = 1'b0;
        cfg.data  = '0;
        #2;
        check_outputs_zero("reset");
        repeat (2) @(negedge prog_clk);
        pReset = 1'b1;
        repeat (2) @(negedge prog_clk);

        run_load(32'hDEADBEEF, 32'h0F0F0F0F, 32'h80000000, 1'b0, 1'b0, 1'b0);
        run_load(32'hDEADBEEF, 32'h0F0F0F0F, 32'h80000000, 1'b1, 1'b0, 1'b0);
        run_load(32'hDEADBEEF, 32'h0F0F0F0F, 32'h80000000, 1'b0, 1'b1, 1'b0);

        @(posedge prog_clk);
        #1;
        start = 1'b1;
        @(posedge prog_clk);
        #1;
        start = 1'b0;
        send_word(32'hCAFEF00D, 32);
        send_word(32'h55AA55AA, 32);
        repeat (5) @(negedge prog_clk);
        cfg.valid = 1'b0;
        pReset    = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        @(negedge prog_clk);
        pReset = 1'b1;
        q.delete();
        @(negedge prog_clk);
        check("idle_after_reset_busy", 128'(busy), 128'(0));
        check("idle_after_reset_ready", 128'(cfg.ready), 128'(0));

        run_load(32'h12345678, 32'hA5A5A5A5, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0);
`ifdef CCFF_READBACK_EN
        run_load(32'hDEADBEEF, 32'h0F0F0F0F, 32'h80000000, 1'b0, 1'b0, 1'b1);
        check("done_with_err", 128'(done), 128'(1));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (compared %0d, mismatched %0d)", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end
endmodule
